fetchstage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage and supplies its inst and addr inputs. It holds the fetch PC and issues in-order requests to instruction memory through a ready/valid handshake. Returned words go into a 2-entry buffer so that decode stalls and variable memory latency are absorbed. A jump from downstream redirects fetch, flushes the buffer and discards in-flight responses.

---
 rtl/fetchstage_if.sv | 27 ++
 rtl/fetchstage.sv | 134 +++++++++++++
 tb/tb_fetchstage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetchstage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave).
interface fetchstage_if #(
    parameter int width = 32
);
    logic             imem_req;
    logic [width-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [width-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetchstage.sv
// Instruction-fetch stage: keeps the fetch PC, issues in-order imem requests under a
// 2-credit window, and buffers returned words in a 2-entry FIFO feeding decode.
module fetchstage #(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = '0,
    parameter logic [width-1:0] NOP_INST = width'(32'h00000013)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jmp,
    input  logic [width-1:0]   jmp_target,
    fetchstage_if.master       imem,
    output logic [width-1:0]   inst,
    output logic [width-1:0]   addr,
    output logic               inst_valid
);

    logic [width-1:0] fpc_reg, fpc_next;
    logic [width-1:0] rpc_reg, rpc_next;
    logic [1:0]       outstanding_reg, outstanding_next;
    logic [1:0]       drop_reg, drop_next;
    logic [1:0]       count_reg, count_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic             wr_ptr_reg, wr_ptr_next;

    logic [width-1:0] entry_addr [2];
    logic [width-1:0] entry_inst [2];

    logic [2:0]       credit_sum;
    logic             req_ok;
    logic             accept;
    logic             resp_drop;
    logic             resp_keep;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic [width-1:0] target_aligned;

    // Words in flight, words to discard and words buffered all share one 2-slot budget,
    // which is what keeps the FIFO from ever overflowing.
    assign credit_sum = {1'b0, outstanding_reg} + {1'b0, drop_reg} + {1'b0, count_reg};
    assign req_ok     = ~rst & ~jmp & (credit_sum < 3'd2);
    assign accept     = req_ok & imem.imem_ready;

    assign imem.imem_req  = req_ok;
    assign imem.imem_addr = fpc_reg;

    assign resp_drop      = imem.imem_rvalid & (drop_reg != 2'd0);
    assign resp_keep      = imem.imem_rvalid & (drop_reg == 2'd0) & (outstanding_reg != 2'd0);
    assign push           = resp_keep & ~jmp;
    assign fifo_nonempty  = (count_reg != 2'd0);
    assign pop            = ~stall & ~jmp & fifo_nonempty;
    assign target_aligned = jmp_target & ~width'(3);

    always_comb begin
        fpc_next         = fpc_reg;
        rpc_next         = rpc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;

        if (jmp) begin
            // Everything still in flight, including a word landing this cycle, is discarded.
            fpc_next         = target_aligned;
            rpc_next         = target_aligned;
            outstanding_next = 2'd0;
            drop_next        = outstanding_reg + drop_reg - 2'(resp_keep) - 2'(resp_drop);
            count_next       = 2'd0;
            rd_ptr_next      = 1'b0;
            wr_ptr_next      = 1'b0;
        end else begin
            if (accept) begin
                fpc_next = fpc_reg + width'(4);
            end
            if (push) begin
                rpc_next    = rpc_reg + width'(4);
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            outstanding_next = outstanding_reg + 2'(accept) - 2'(resp_keep);
            drop_next        = drop_reg - 2'(resp_drop);
            count_next       = count_reg + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_reg         <= RESET_PC;
            rpc_reg         <= RESET_PC;
            outstanding_reg <= 2'd0;
            drop_reg        <= 2'd0;
            count_reg       <= 2'd0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
        end else begin
            fpc_reg         <= fpc_next;
            rpc_reg         <= rpc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Buffer payload needs no reset: count_reg alone decides which entries are live.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [width-1:0] addr_reg;
            logic [width-1:0] inst_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    addr_reg <= rpc_reg;
                    inst_reg <= imem.imem_rdata;
                end
            end

            assign entry_addr[gi] = addr_reg;
            assign entry_inst[gi] = inst_reg;
        end
    endgenerate

    assign inst_valid = fifo_nonempty;
    assign inst       = fifo_nonempty ? entry_inst[rd_ptr_reg] : NOP_INST;
    assign addr       = fifo_nonempty ? entry_addr[rd_ptr_reg] : rpc_reg;

endmodule

// File: tb/tb_fetchstage.sv
// Directed bench for fetchstage: a small in-order instruction memory with selectable
// latency and ready toggling, plus a pop scoreboard tracking the expected fetch address.
module tb_fetchstage;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        inst_valid;

    fetchstage_if #(.width(32)) imem ();

    fetchstage #(
        .width   (32),
        .RESET_PC(32'h00000000),
        .NOP_INST(32'h00000013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp       (jmp),
        .jmp_target(jmp_target),
        .imem      (imem.master),
        .inst      (inst),
        .addr      (addr),
        .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    mreq_t       memq [$];
    mreq_t       dummy;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_pops = 0;
    int          p0;
    bit          toggle = 1'b0;
    bit          acc_s, rv_s, rst_s;
    bit          seen_zero = 1'b0;
    logic [31:0] acc_addr_s;
    logic [31:0] exp_addr = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Mid-cycle: sample handshakes for the memory model and score any pop decode takes.
    task automatic mid();
        @(negedge clk);
        acc_s      = imem.imem_req & imem.imem_ready;
        acc_addr_s = imem.imem_addr;
        rv_s       = imem.imem_rvalid;
        rst_s      = rst;
        chk("inflight_le2", {31'b0, memq.size() <= 2}, 32'd1);
        if (inst_valid && !stall && !jmp && !rst) begin
            $display("pop addr=%h inst=%h", addr, inst);
            chk("pop_addr", addr, exp_addr);
            chk("pop_inst", inst, word_of(exp_addr));
            if (exp_addr == 32'h0 && addr == 32'h0) seen_zero = 1'b1;
            exp_addr += 32'd4;
            n_pops++;
        end
    endtask

    // Just after the edge: advance the memory model and drive the next cycle's response.
    task automatic edge_();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            memq.delete();
        end else begin
            if (rv_s) dummy = memq.pop_front();
            if (acc_s) memq.push_back('{a: acc_addr_s, due: cyc - 1 + lat});
        end
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = word_of(memq[0].a);
        end else begin
            imem.imem_rvalid = 1'b0;
            imem.imem_rdata  = 32'h0;
        end
        imem.imem_ready = toggle ? ~imem.imem_ready : 1'b1;
    endtask

    task automatic cycle();
        mid();
        edge_();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        stall            = 1'b0;
        jmp              = 1'b0;
        jmp_target       = 32'h0;
        imem.imem_ready  = 1'b1;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;

        // Reset state
        cycle();
        mid();
        chk("rst_req", imem.imem_req, 0);
        chk("rst_inst", inst, NOP);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", inst_valid, 0);
        edge_();

        // Free run, 1-cycle memory
        rst = 1'b0;
        mid();
        chk("c0_valid", inst_valid, 0);
        chk("c0_inst", inst, NOP);
        chk("c0_req", imem.imem_req, 1);
        chk("c0_iaddr", imem.imem_addr, 32'h0);
        edge_();
        mid();
        chk("c1_req", imem.imem_req, 1);
        chk("c1_iaddr", imem.imem_addr, 32'h4);
        chk("c1_valid", inst_valid, 0);
        edge_();
        mid();
        chk("c2_valid", inst_valid, 1);
        chk("c2_addr", addr, 32'h0);
        edge_();
        for (int n = 0; n < 40 && exp_addr != 32'h10; n++) cycle();
        chk("reach_10", exp_addr, 32'h10);

        // Stall with 0x10 and 0x14 buffered
        stall = 1'b1;
        cycle();
        cycle();
        for (int n = 0; n < 5; n++) begin
            mid();
            chk("stall_valid", inst_valid, 1);
            chk("stall_addr", addr, 32'h10);
            chk("stall_inst", inst, word_of(32'h10));
            chk("stall_req", imem.imem_req, 0);
            edge_();
        end
        stall = 1'b0;
        mid();
        chk("rel0_addr", addr, 32'h10);
        edge_();
        mid();
        chk("rel1_valid", inst_valid, 1);
        chk("rel1_addr", addr, 32'h14);
        edge_();

        // Redirect with two requests outstanding, 3-cycle memory
        lat = 3;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_addr = 32'h0;
        cycle();
        cycle();
        jmp        = 1'b1;
        jmp_target = 32'h103;
        exp_addr   = 32'h100;
        mid();
        chk("j_req", imem.imem_req, 0);
        chk("j_inflight", memq.size(), 2);
        edge_();
        jmp = 1'b0;
        mid();
        chk("jd_req", imem.imem_req, 0);
        chk("jd_valid", inst_valid, 0);
        chk("jd_addr", addr, 32'h100);
        edge_();
        mid();
        chk("jn_req", imem.imem_req, 1);
        chk("jn_iaddr", imem.imem_addr, 32'h100);
        edge_();
        for (int n = 0; n < 20 && !inst_valid; n++) cycle();

        // Redirect coinciding with a response while stalled
        stall      = 1'b1;
        jmp        = 1'b1;
        jmp_target = 32'h200;
        mid();
        chk("t_valid", inst_valid, 1);
        chk("t_addr", addr, 32'h100);
        chk("t_inst", inst, word_of(32'h100));
        chk("t_rvalid", imem.imem_rvalid, 1);
        chk("t_req", imem.imem_req, 0);
        edge_();
        exp_addr = 32'h200;
        jmp = 1'b0;
        mid();
        chk("jr_valid", inst_valid, 0);
        chk("jr_addr", addr, 32'h200);
        chk("jr_inst", inst, NOP);
        chk("jr_req", imem.imem_req, 1);
        chk("jr_iaddr", imem.imem_addr, 32'h200);
        edge_();

        // Toggling ready, 3-cycle latency: scoreboard checks contiguity
        stall  = 1'b0;
        toggle = 1'b1;
        p0     = n_pops;
        for (int n = 0; n < 60; n++) cycle();
        chk("progress", {31'b0, (n_pops - p0) >= 8}, 32'd1);

        // Reset mid-stream with the buffer full
        toggle = 1'b0;
        stall  = 1'b1;
        for (int n = 0; n < 10; n++) cycle();
        mid();
        chk("full_valid", inst_valid, 1);
        chk("full_req", imem.imem_req, 0);
        edge_();
        rst = 1'b1;
        mid();
        chk("rstm_req", imem.imem_req, 0);
        edge_();
        rst      = 1'b0;
        stall    = 1'b0;
        exp_addr = 32'h0;
        mid();
        chk("ra_valid", inst_valid, 0);
        chk("ra_addr", addr, 32'h0);
        chk("ra_inst", inst, NOP);
        chk("ra_req", imem.imem_req, 1);
        chk("ra_iaddr", imem.imem_addr, 32'h0);
        edge_();

        // Address wrap after a redirect near the top of memory
        lat = 1;
        for (int n = 0; n < 6; n++) cycle();
        jmp        = 1'b1;
        jmp_target = 32'hFFFFFFFB;
        exp_addr   = 32'hFFFFFFF8;
        seen_zero  = 1'b0;
        mid();
        edge_();
        jmp = 1'b0;
        for (int n = 0; n < 30; n++) cycle();
        chk("wrap_seen", {31'b0, seen_zero}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
